// File: rtl/alu_op_seq_if.sv
// Bundle of command, ALU and result signals around the ALU sequencer.
// The sequencer takes the slave side; whoever feeds commands and hosts the ALU takes the master side.
interface alu_op_seq_if;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_a;
    logic [3:0] in_b;
    logic [2:0] in_op;
    logic       in_cin;

    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [2:0] alu_c;
    logic       alu_cin;
    logic [3:0] alu_result;
    logic       alu_overflow;
    logic       alu_carry;
    logic       alu_size;

    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_result;
    logic [3:0] out_flags;
    logic [2:0] out_op;

    logic       busy;
    logic [7:0] op_count;

    modport master (
        output in_valid, in_a, in_b, in_op, in_cin,
        output alu_result, alu_overflow, alu_carry, alu_size,
        output out_ready,
        input  in_ready,
        input  alu_a, alu_b, alu_c, alu_cin,
        input  out_valid, out_result, out_flags, out_op,
        input  busy, op_count
    );

    modport slave (
        input  in_valid, in_a, in_b, in_op, in_cin,
        input  alu_result, alu_overflow, alu_carry, alu_size,
        input  out_ready,
        output in_ready,
        output alu_a, alu_b, alu_c, alu_cin,
        output out_valid, out_result, out_flags, out_op,
        output busy, op_count
    );
endinterface

// File: rtl/alu_op_seq.sv
// Sequencer around an external combinational 4-bit ALU: latches one command, lets the ALU settle
// for a cycle, then holds the result and masked flags until downstream accepts it.
module alu_op_seq (
    input  logic         clk,
    input  logic         rst_n,
    alu_op_seq_if.slave  bus
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_CMP = 3'b110;
    localparam logic [2:0] OP_EQ  = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state;
    state_t     state_next;

    logic [3:0] cmd_a;
    logic [3:0] cmd_b;
    logic [2:0] cmd_op;
    logic       cmd_cin;

    logic       out_valid_q;
    logic [3:0] out_result_q;
    logic [3:0] out_flags_q;
    logic [2:0] out_op_q;
    logic [7:0] op_count_q;

    logic       in_ready;
    logic       in_fire;
    logic       out_fire;
    logic       op_is_arith;
    logic       op_is_cmp;
    logic       alu_cin;
    logic [3:0] flags_next;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // In DONE the command port is only open while the result leaves, so a new command can chain directly into EXEC.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (bus.in_valid) begin
                    state_next = EXEC;
                end
            end
            EXEC: begin
                state_next = DONE;
            end
            DONE: begin
                in_ready = bus.out_ready;
                if (bus.out_ready) begin
                    state_next = bus.in_valid ? EXEC : IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign in_fire  = bus.in_valid && in_ready;
    assign out_fire = out_valid_q && bus.out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cmd_a   <= 4'h0;
            cmd_b   <= 4'h0;
            cmd_op  <= 3'b000;
            cmd_cin <= 1'b0;
        end else if (in_fire) begin
            cmd_a   <= bus.in_a;
            cmd_b   <= bus.in_b;
            cmd_op  <= bus.in_op;
            cmd_cin <= bus.in_cin;
        end
    end

    // Subtract-style ops (sub, compare, equality) need carry-in 1 to form a + ~b + 1 inside the ALU.
    always_comb begin
        alu_cin = 1'b0;
        case (cmd_op)
            OP_ADD:                 alu_cin = cmd_cin;
            OP_SUB, OP_CMP, OP_EQ:  alu_cin = 1'b1;
            default:                alu_cin = 1'b0;
        endcase
    end

    assign op_is_arith = (cmd_op == OP_ADD) || (cmd_op == OP_SUB) ||
                         (cmd_op == OP_CMP) || (cmd_op == OP_EQ);
    assign op_is_cmp   = (cmd_op == OP_CMP) || (cmd_op == OP_EQ);

    // ALU flags are meaningless for logic ops, so they are masked rather than trusted.
    assign flags_next = {
        op_is_cmp   & bus.alu_size,
        op_is_arith & bus.alu_carry,
        op_is_arith & bus.alu_overflow,
        (bus.alu_result == 4'h0)
    };

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_result_q <= 4'h0;
            out_flags_q  <= 4'h0;
            out_op_q     <= 3'b000;
        end else if (state == EXEC) begin
            out_valid_q  <= 1'b1;
            out_result_q <= bus.alu_result;
            out_flags_q  <= flags_next;
            out_op_q     <= cmd_op;
        end else if (out_fire) begin
            out_valid_q  <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_count_q <= 8'h00;
        end else if (out_fire) begin
            op_count_q <= op_count_q + 8'h01;
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.alu_a      = cmd_a;
    assign bus.alu_b      = cmd_b;
    assign bus.alu_c      = cmd_op;
    assign bus.alu_cin    = alu_cin;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_result = out_result_q;
    assign bus.out_flags  = out_flags_q;
    assign bus.out_op     = out_op_q;
    assign bus.busy       = (state != IDLE);
    assign bus.op_count   = op_count_q;

endmodule

// File: tb/tb_alu_op_seq.sv
// Scoreboard bench for alu_op_seq: a stand-in ALU drives the ALU side, a driver issues commands and
// queues expected results from an arithmetic model, and a monitor pops and compares on each output handshake.
module tb_alu_op_seq;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] op;
        logic       cin_exp;
        logic [3:0] result;
        logic [3:0] flags;
    } exp_t;

    logic clk;
    logic rst_n;

    alu_op_seq_if bus ();

    alu_op_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int         n_checks = 0;
    int         n_fail   = 0;
    int         cycle    = 0;
    exp_t       exp_q[$];
    logic [7:0] exp_count = 8'h00;
    int         ready_mode = 1;
    bit         mon_en = 1'b0;
    bit         gap_check = 1'b0;
    int         gap_prev = -1;
    int         first_in_cycle;
    int         last_in_cycle;

    logic [3:0] alu_bb;
    logic [4:0] alu_sum;
    logic       alu_ov_raw;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle++;

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Stand-in ALU; flags it drives for ops where they carry no meaning are deliberately noisy.
    always_comb begin
        alu_bb     = (bus.alu_c inside {3'd1, 3'd6, 3'd7}) ? ~bus.alu_b : bus.alu_b;
        alu_sum    = {1'b0, bus.alu_a} + {1'b0, alu_bb} + {4'b0000, bus.alu_cin};
        alu_ov_raw = (bus.alu_a[3] == alu_bb[3]) && (alu_sum[3] != bus.alu_a[3]);
        bus.alu_result   = alu_sum[3:0];
        bus.alu_carry    = alu_sum[4];
        bus.alu_overflow = alu_ov_raw;
        bus.alu_size     = bus.alu_a[1] ^ bus.alu_b[2] ^ 1'b1;
        case (bus.alu_c)
            3'd2, 3'd3, 3'd4, 3'd5: begin
                bus.alu_carry    = ~bus.alu_a[0];
                bus.alu_overflow = bus.alu_a[3] | bus.alu_b[3];
                bus.alu_size     = bus.alu_a[2] | bus.alu_b[1];
                case (bus.alu_c)
                    3'd2:    bus.alu_result = ~bus.alu_a;
                    3'd3:    bus.alu_result = bus.alu_a & bus.alu_b;
                    3'd4:    bus.alu_result = bus.alu_a | bus.alu_b;
                    default: bus.alu_result = bus.alu_a ^ bus.alu_b;
                endcase
            end
            3'd6:    bus.alu_size = alu_sum[3] ^ alu_ov_raw;
            3'd7:    bus.alu_size = (alu_sum[3:0] == 4'h0);
            default: ;
        endcase
    end

    always @(negedge clk) begin
        case (ready_mode)
            0:       bus.out_ready = ($urandom_range(0, 3) != 0);
            2:       bus.out_ready = 1'b0;
            default: bus.out_ready = 1'b1;
        endcase
    end

    function automatic int sext4(input logic [3:0] v);
        return v[3] ? int'(v) - 16 : int'(v);
    endfunction

    // Expected outcome straight from the arithmetic meaning of each op.
    function automatic exp_t model(input logic [3:0] a, input logic [3:0] b,
                                   input logic [2:0] op, input logic cin);
        exp_t e;
        int   ua, ub, sa, sb, r, sr;
        logic carry, ov, size;
        ua = int'(a); ub = int'(b); sa = sext4(a); sb = sext4(b);
        carry = 1'b0; ov = 1'b0; size = 1'b0; r = 0;
        case (op)
            3'd0: begin
                r     = ua + ub + int'(cin);
                sr    = sa + sb + int'(cin);
                carry = (r > 15);
                ov    = (sr > 7) || (sr < -8);
            end
            3'd1, 3'd6, 3'd7: begin
                r     = ua - ub;
                sr    = sa - sb;
                carry = (ua >= ub);
                ov    = (sr > 7) || (sr < -8);
                if (op == 3'd6) size = (sa < sb);
                if (op == 3'd7) size = (ua == ub);
            end
            3'd2:    r = 15 - ua;
            3'd3:    r = ua & ub;
            3'd4:    r = ua | ub;
            default: r = ua ^ ub;
        endcase
        e.a       = a;
        e.b       = b;
        e.op      = op;
        e.cin_exp = (op == 3'd0) ? cin : (op inside {3'd1, 3'd6, 3'd7});
        e.result  = 4'(r & 15);
        e.flags   = {size, carry, ov, (e.result == 4'h0)};
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cycle);
        end
    endtask

    // Presents one command and returns just after the clock edge on which it was accepted.
    task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b,
                                 input logic [2:0] op, input logic cin);
        int waited;
        waited = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_op    = op;
        bus.in_cin   = cin;
        #1;
        while (!bus.in_ready && waited < 60) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (!bus.in_ready) begin
            checkOutput("in_handshake_timeout", 16'(bus.in_ready), 16'h1);
            bus.in_valid = 1'b0;
        end else begin
            exp_q.push_back(model(a, b, op, cin));
            last_in_cycle = cycle;
            @(posedge clk);
            #1;
            bus.in_valid = 1'b0;
        end
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            bus.in_a     = 4'($urandom_range(0, 15));
            bus.in_b     = 4'($urandom_range(0, 15));
            bus.in_op    = 3'($urandom_range(0, 7));
            bus.in_cin   = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic randomOp();
        applyStimulus(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                      3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
    endtask

    task automatic waitDrain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(negedge clk);
            #2;
            n++;
        end
        if (exp_q.size() != 0) checkOutput(name, 16'(exp_q.size()), 16'h0);
    endtask

    task automatic resetDut();
        @(negedge clk);
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        exp_q.delete();
        exp_count = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: checks the running handshake count every cycle and each result as it leaves.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (mon_en && rst_n) begin
                checkOutput("op_count", 16'(bus.op_count), 16'(exp_count));
                if (bus.out_valid && bus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        checkOutput("unexpected_output", 16'(bus.out_valid), 16'h0);
                    end else begin
                        e = exp_q.pop_front();
                        checkOutput("out_result", 16'(bus.out_result), 16'(e.result));
                        checkOutput("out_flags",  16'(bus.out_flags),  16'(e.flags));
                        checkOutput("out_op",     16'(bus.out_op),     16'(e.op));
                        checkOutput("alu_cin",    16'(bus.alu_cin),    16'(e.cin_exp));
                        checkOutput("alu_a",      16'(bus.alu_a),      16'(e.a));
                        checkOutput("alu_b",      16'(bus.alu_b),      16'(e.b));
                        checkOutput("alu_c",      16'(bus.alu_c),      16'(e.op));
                    end
                    if (gap_check) begin
                        if (gap_prev >= 0) checkOutput("out_gap", 16'(cycle - gap_prev), 16'd2);
                        gap_prev = cycle;
                    end
                    exp_count = exp_count + 8'h01;
                end
            end
        end
    end

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_a      = 4'h0;
        bus.in_b      = 4'h0;
        bus.in_op     = 3'b000;
        bus.in_cin    = 1'b0;
        bus.out_ready = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #2;
        checkOutput("rst_out_valid",  16'(bus.out_valid),  16'h0);
        checkOutput("rst_out_result", 16'(bus.out_result), 16'h0);
        checkOutput("rst_out_flags",  16'(bus.out_flags),  16'h0);
        checkOutput("rst_out_op",     16'(bus.out_op),     16'h0);
        checkOutput("rst_op_count",   16'(bus.op_count),   16'h0);
        checkOutput("rst_alu_abc",    {5'b0, bus.alu_a, bus.alu_b, bus.alu_c}, 16'h0);
        checkOutput("rst_alu_cin",    16'(bus.alu_cin),    16'h0);
        checkOutput("rst_busy",       16'(bus.busy),       16'h0);
        checkOutput("rst_in_ready",   16'(bus.in_ready),   16'h1);
        mon_en = 1'b1;

        // add 7+1: latency and signed overflow
        ready_mode = 1;
        applyStimulus(4'h7, 4'h1, 3'd0, 1'b0);
        @(negedge clk);
        #2;
        checkOutput("lat_t1_out_valid", 16'(bus.out_valid), 16'h0);
        checkOutput("lat_t1_busy",      16'(bus.busy),      16'h1);
        checkOutput("lat_t1_in_ready",  16'(bus.in_ready),  16'h0);
        @(negedge clk);
        #2;
        checkOutput("lat_t2_out_valid", 16'(bus.out_valid),  16'h1);
        checkOutput("add_result",       16'(bus.out_result), 16'h8);
        checkOutput("add_flags",        16'(bus.out_flags),  16'b0010);
        waitDrain("drain_add");

        // sub 3-3: carry-in forced, zero result
        applyStimulus(4'h3, 4'h3, 3'd1, 1'b0);
        @(negedge clk);
        #2;
        checkOutput("sub_alu_cin", 16'(bus.alu_cin), 16'h1);
        @(negedge clk);
        #2;
        checkOutput("sub_result", 16'(bus.out_result), 16'h0);
        checkOutput("sub_zero",   16'(bus.out_flags[0]), 16'h1);
        waitDrain("drain_sub");

        // and F&0 held under backpressure, with ignored commands offered meanwhile
        ready_mode = 2;
        idleCycles(2);
        applyStimulus(4'hF, 4'h0, 3'd3, 1'b1);
        for (int i = 0; i < 4 && !bus.out_valid; i++) begin
            @(negedge clk);
            #2;
        end
        checkOutput("stall_out_valid_rise", 16'(bus.out_valid), 16'h1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_a     = 4'h5;
            bus.in_b     = 4'h9;
            bus.in_op    = 3'd5;
            #2;
            checkOutput("stall_out_valid", 16'(bus.out_valid),  16'h1);
            checkOutput("stall_result",    16'(bus.out_result), 16'h0);
            checkOutput("stall_flags",     16'(bus.out_flags),  16'b0001);
            checkOutput("stall_in_ready",  16'(bus.in_ready),   16'h0);
            checkOutput("stall_alu_a",     16'(bus.alu_a),      16'hF);
            checkOutput("stall_op_count",  16'(bus.op_count),   16'(exp_count));
        end
        bus.in_valid = 1'b0;
        ready_mode   = 1;
        waitDrain("drain_stall");

        // ten back-to-back commands at full rate
        resetDut();
        gap_prev  = -1;
        gap_check = 1'b1;
        for (int i = 0; i < 10; i++) begin
            randomOp();
            if (i == 0) first_in_cycle = last_in_cycle;
        end
        checkOutput("b2b_in_span", 16'(last_in_cycle - first_in_cycle), 16'd18);
        waitDrain("drain_b2b");
        @(negedge clk);
        #2;
        gap_check = 1'b0;
        checkOutput("b2b_op_count", 16'(bus.op_count), 16'd10);

        // reset while in EXEC discards the command
        applyStimulus(4'hA, 4'h6, 3'd5, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        exp_q.delete();
        exp_count = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
        #2;
        checkOutput("rexec_out_valid", 16'(bus.out_valid), 16'h0);
        checkOutput("rexec_in_ready",  16'(bus.in_ready),  16'h1);
        checkOutput("rexec_busy",      16'(bus.busy),      16'h0);
        checkOutput("rexec_op_count",  16'(bus.op_count),  16'h0);
        checkOutput("rexec_alu_abc",   {5'b0, bus.alu_a, bus.alu_b, bus.alu_c}, 16'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #2;
            checkOutput("rexec_no_result", 16'(bus.out_valid), 16'h0);
        end

        // randomized traffic with random gaps and backpressure
        ready_mode = 0;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) idleCycles(int'($urandom_range(1, 3)));
            randomOp();
        end
        ready_mode = 1;
        waitDrain("drain_random");

        // op_count wrap
        resetDut();
        for (int i = 0; i < 256; i++) randomOp();
        waitDrain("drain_wrap");
        @(negedge clk);
        #2;
        checkOutput("wrap_op_count_256", 16'(bus.op_count), 16'h0);
        randomOp();
        waitDrain("drain_wrap_257");
        @(negedge clk);
        #2;
        checkOutput("wrap_op_count_257", 16'(bus.op_count), 16'h1);

        idleCycles(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
